// File: rtl/ula_seq.sv
// ----------------------------------------------------------------------------
// ula_seq
// Sequential WIDTH-bit arithmetic/logic unit. It has a start/ready/valid
// handshake, registered result flags, an internal accumulator and an optional
// multi-cycle shift-add multiplier.
//
// Optional feature macro: ULA_MUL_EN
//   defined   : MUL (Sel=101) runs a WIDTH-cycle shift-add. ready is low while
//               the multiply is in progress.
//   undefined : there is no multiplier and ready is tied to 1. Sel=101 is an
//               illegal op and returns Res=0, OVRF=1, ZERO=1 after one cycle.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, taken only while ready=1
//   A, B   in   WIDTH-bit operands (two's complement for signed flags)
//   Sel    in   opcode: ADD SUB AND OR XOR MUL ACC CLR (000..111)
//   ready  out  a start presented now will be accepted
//   valid  out  one-cycle pulse when Res/OVRF/ZERO carry a new result
//   Res    out  registered result
//   OVRF   out  registered overflow flag
//   ZERO   out  registered "new Res is all zeros" flag
// ----------------------------------------------------------------------------
module ula_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] Res,
    output logic             OVRF,
    output logic             ZERO
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    // Signed overflow of s = x + y: operands agree in sign, result differs.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of s = x - y: operands differ in sign, result differs from x.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_p0;
    logic signed [WIDTH-1:0] res_p0;
    logic                    ovf_p0;
    logic                    acc_we_p0;
    logic                    mul_issue;
    logic                    alu_issue;

    // ---- stage p0: single-cycle operations, evaluated on the live inputs ----
    always_comb begin
        res_p0    = '0;
        ovf_p0    = 1'b0;
        acc_p0    = acc;
        acc_we_p0 = 1'b0;
        case (Sel)
            OP_ADD: begin
                res_p0 = A + B;
                ovf_p0 = add_ovf(A, B, res_p0);
            end
            OP_SUB: begin
                res_p0 = A - B;
                ovf_p0 = sub_ovf(A, B, res_p0);
            end
            OP_AND: res_p0 = A & B;
            OP_OR:  res_p0 = A | B;
            OP_XOR: res_p0 = A ^ B;
            // Only reaches the output register when there is no multiplier:
            // then it is the illegal-op response.
            OP_MUL: ovf_p0 = 1'b1;
            OP_ACC: begin
                acc_p0    = acc + A;
                res_p0    = acc_p0;
                ovf_p0    = add_ovf(acc, A, acc_p0);
                acc_we_p0 = 1'b1;
            end
            OP_CLR: begin
                acc_p0    = '0;
                acc_we_p0 = 1'b1;
            end
        endcase
    end

`ifdef ULA_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       a_mul;
    logic [WIDTH-1:0]       b_mul;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     prod_nxt;
    logic                   mul_done;

    assign ready     = (state == IDLE);
    assign mul_issue = start && ready && (Sel == OP_MUL);
    assign mul_done  = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (mul_issue)
                cnt <= '0;
            else if (state == BUSY)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul_issue) state_nxt = BUSY;
            BUSY: if (mul_done)  state_nxt = IDLE;
        endcase
    end

    // One partial product per cycle: bit cnt of B selects A shifted by cnt.
    always_comb begin
        prod_nxt = prod;
        if (b_mul[cnt])
            prod_nxt = prod + ({{WIDTH{1'b0}}, a_mul} << cnt);
    end

    // Operand latches and partial product need no reset: every multiply
    // reloads them at issue.
    always_ff @(posedge clk) begin
        if (mul_issue) begin
            a_mul <= A;
            b_mul <= B;
            prod  <= '0;
        end else if (state == BUSY) begin
            prod  <= prod_nxt;
        end
    end
`else
    assign ready     = 1'b1;
    assign mul_issue = 1'b0;
`endif

    assign alu_issue = start && ready && !mul_issue;

    // ---- stage p1: registered result, flags, accumulator and valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Res   <= '0;
            OVRF  <= 1'b0;
            ZERO  <= 1'b0;
            valid <= 1'b0;
            acc   <= '0;
        end else begin
            valid <= 1'b0;
            if (alu_issue) begin
                Res   <= res_p0;
                OVRF  <= ovf_p0;
                ZERO  <= (res_p0 == '0);
                valid <= 1'b1;
                if (acc_we_p0)
                    acc <= acc_p0;
            end
`ifdef ULA_MUL_EN
            else if (mul_done) begin
                Res   <= prod_nxt[WIDTH-1:0];
                OVRF  <= |prod_nxt[2*WIDTH-1:WIDTH];
                ZERO  <= (prod_nxt[WIDTH-1:0] == '0);
                valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;

    localparam int W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Sel;
    logic         ready;
    logic         valid;
    logic [W-1:0] Res;
    logic         OVRF;
    logic         ZERO;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    ula_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Sel   (Sel),
        .ready (ready),
        .valid (valid),
        .Res   (Res),
        .OVRF  (OVRF),
        .ZERO  (ZERO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ULA_MUL_EN
    // Issue a MUL, optionally present an ADD start during the first BUSY
    // cycles, and expect exactly one valid pulse after W cycles.
    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic eo, input logic inject);
        int lat;
        int busy_hi;
        int pulses;
        @(negedge clk);
        start = 1'b1; Sel = OP_MUL; A = a; B = b;
        tick();
        check({name, "_ready_low"}, ready, 0);
        lat     = 0;
        busy_hi = 0;
        while (lat < 12) begin
            @(negedge clk);
            start = inject && (lat < 2);
            Sel   = OP_ADD;
            A     = 4'b0001;
            B     = 4'b0001;
            tick();
            lat++;
            if (valid) break;
            if (ready) busy_hi++;
        end
        start = 1'b0;
        check({name, "_latency"}, lat, W);
        check({name, "_ready_during_busy"}, busy_hi, 0);
        check({name, "_res"}, Res, er);
        check({name, "_ovf"}, OVRF, eo);
        check({name, "_zero"}, ZERO, (er == '0));
        check({name, "_ready_after"}, ready, 1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid) pulses++;
        end
        check({name, "_no_extra_valid"}, pulses, 0);
        check({name, "_res_hold"}, Res, er);
    endtask
`endif

    initial begin
        vecs[0]  = '{OP_CLR, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[1]  = '{OP_ACC, 4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b0};
        vecs[2]  = '{OP_ACC, 4'b0011, 4'b0000, 4'b0110, 1'b0, 1'b0};
        vecs[3]  = '{OP_ACC, 4'b0011, 4'b0101, 4'b1001, 1'b1, 1'b0};
        vecs[4]  = '{OP_ACC, 4'b0111, 4'b1111, 4'b0000, 1'b0, 1'b1};
        vecs[5]  = '{OP_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b1, 1'b0};
        vecs[6]  = '{OP_SUB, 4'b1010, 4'b0111, 4'b0011, 1'b1, 1'b0};
        vecs[7]  = '{OP_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1};
        vecs[8]  = '{OP_SUB, 4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{OP_SUB, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0};
        vecs[10] = '{OP_ADD, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1};
        vecs[11] = '{OP_AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
        vecs[12] = '{OP_OR,  4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0};
        vecs[13] = '{OP_XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        Sel   = OP_ADD;
        A     = '0;
        B     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_res", Res, 0);
        check("rst_ovf", OVRF, 0);
        check("rst_zero", ZERO, 0);
        check("rst_valid", valid, 0);
        check("rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", valid, 0);
        check("post_rst_ready", ready, 1);

        // Back-to-back single-cycle operations, one per clock.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            start = 1'b1;
            Sel   = vecs[i].sel;
            A     = vecs[i].a;
            B     = vecs[i].b;
            tick();
            check($sformatf("v%0d_valid", i), valid, 1);
            check($sformatf("v%0d_res", i), Res, vecs[i].res);
            check($sformatf("v%0d_ovf", i), OVRF, vecs[i].ovf);
            check($sformatf("v%0d_zero", i), ZERO, vecs[i].zero);
            check($sformatf("v%0d_ready", i), ready, 1);
        end

        // Outputs hold once start drops.
        @(negedge clk);
        start = 1'b0;
        Sel   = OP_ADD;
        A     = 4'b0101;
        B     = 4'b0101;
        tick();
        check("idle_valid", valid, 0);
        check("idle_res_hold", Res, 4'b0110);
        check("idle_ovf_hold", OVRF, 0);
        check("idle_zero_hold", ZERO, 0);

`ifdef ULA_MUL_EN
        run_mul("mul_3x5", 4'b0011, 4'b0101, 4'b1111, 1'b0, 1'b0);
        run_mul("mul_7x3", 4'b0111, 4'b0011, 4'b0101, 1'b1, 1'b0);
        run_mul("mul_ign", 4'b0010, 4'b0110, 4'b1100, 1'b0, 1'b1);

        // Reset during the second BUSY cycle aborts the multiply.
        run_mul("mul_pre", 4'b0111, 4'b0011, 4'b0101, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; Sel = OP_MUL; A = 4'b0011; B = 4'b0101;
        tick();
        @(negedge clk);
        start = 1'b0;
        tick();
        check("abort_busy", ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_res", Res, 0);
        check("abort_ovf", OVRF, 0);
        check("abort_valid", valid, 0);
        check("abort_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (valid) pulses++;
            end
            check("abort_no_valid", pulses, 0);
            check("abort_res_hold", Res, 0);
        end
`else
        // Without the multiplier Sel=101 is an illegal single-cycle op.
        @(negedge clk);
        start = 1'b1; Sel = OP_MUL; A = 4'b0011; B = 4'b0101;
        check("ill_ready_before", ready, 1);
        tick();
        check("ill_valid", valid, 1);
        check("ill_res", Res, 0);
        check("ill_ovf", OVRF, 1);
        check("ill_zero", ZERO, 1);
        check("ill_ready", ready, 1);
        @(negedge clk);
        start = 1'b0;
        tick();
        check("ill_valid_drop", valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
